// File: rtl/plic_lite_if.sv
// D-bus responder interface for the PLIC window: request/response handshake signals.
interface plic_lite_if;
    logic        bus_req;
    logic        bus_we;
    logic [23:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/plic_lite.sv
// Single-context platform interrupt controller: gateways, priority arbiter, claim/complete.
// Optional macro PLIC_EDGE_TRIG_EN selects rising-edge gateways instead of level-triggered.
module plic_lite #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    plic_lite_if.slave         bus,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               irq_ext
);
    localparam int unsigned ID_W = 5;
    localparam logic [23:0] A_PEND = 24'h001000;
    localparam logic [23:0] A_EN   = 24'h002000;
    localparam logic [23:0] A_THR  = 24'h200000;
    localparam logic [23:0] A_CLM  = 24'h200004;

    logic [PRIO_W-1:0]  r_prio [1:NUM_SRC];
    logic [NUM_SRC:1]   r_en;
    logic [NUM_SRC:1]   r_pend;
    logic [NUM_SRC:1]   r_infl;
    logic [PRIO_W-1:0]  r_thr;
    logic               r_ack;
    logic [31:0]        r_rdata;
    logic               r_irq;

    logic [NUM_SRC:1]   w_src;
    logic [NUM_SRC:1]   w_set;
    logic               w_accept;
    logic               w_prio_rgn;
    logic [9:0]         w_idx;
    logic [ID_W-1:0]    w_win_id;
    logic [PRIO_W-1:0]  w_win_prio;
    logic [31:0]        w_rdata;
    logic               w_claim;
    logic               w_complete;
    logic               w_unused;

    assign w_src      = irq_src;
    assign w_accept   = bus.bus_req && !r_ack;
    assign w_prio_rgn = (bus.bus_addr[23:12] == 12'h000);
    assign w_idx      = bus.bus_addr[11:2];
    assign w_claim    = w_accept && !bus.bus_we && (bus.bus_addr == A_CLM);
    assign w_complete = w_accept &&  bus.bus_we && (bus.bus_addr == A_CLM);
    assign w_unused   = ^{bus.bus_addr[1:0], bus.bus_wdata};

`ifdef PLIC_EDGE_TRIG_EN
    logic [NUM_SRC:1] r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_prev <= '0;
        else     r_prev <= w_src;
    end

    assign w_set = w_src & ~r_prev;
`else
    assign w_set = w_src;
`endif

    // Strictly-greater scan in ascending ID order: ties keep the lowest ID, prio 0 never wins.
    always_comb begin
        w_win_id   = '0;
        w_win_prio = '0;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            if (r_pend[i] && r_en[i] && (r_prio[i] > w_win_prio)) begin
                w_win_id   = ID_W'(i);
                w_win_prio = r_prio[i];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_prio_rgn) begin
            for (int unsigned i = 1; i <= NUM_SRC; i++) begin
                if (w_idx == 10'(i)) w_rdata = 32'(r_prio[i]);
            end
        end else if (bus.bus_addr == A_PEND) begin
            w_rdata = 32'({r_pend, 1'b0});
        end else if (bus.bus_addr == A_EN) begin
            w_rdata = 32'({r_en, 1'b0});
        end else if (bus.bus_addr == A_THR) begin
            w_rdata = 32'(r_thr);
        end else if (bus.bus_addr == A_CLM) begin
            w_rdata = 32'(w_win_id);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 1; i <= NUM_SRC; i++) r_prio[i] <= '0;
            r_en    <= '0;
            r_pend  <= '0;
            r_infl  <= '0;
            r_thr   <= '0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_ack <= w_accept;
            if (w_accept) r_rdata <= w_rdata;
            r_irq <= (w_win_id != '0) && (w_win_prio > r_thr);

            if (w_accept && bus.bus_we) begin
                for (int unsigned i = 1; i <= NUM_SRC; i++) begin
                    if (w_prio_rgn && (w_idx == 10'(i))) r_prio[i] <= bus.bus_wdata[PRIO_W-1:0];
                end
                if (bus.bus_addr == A_EN)  r_en  <= bus.bus_wdata[NUM_SRC:1];
                if (bus.bus_addr == A_THR) r_thr <= bus.bus_wdata[PRIO_W-1:0];
            end

            // Gateways: IDLE (!pend,!infl) -> WAIT (pend) -> INFL (infl) -> IDLE.
            for (int unsigned i = 1; i <= NUM_SRC; i++) begin
                if (r_infl[i]) begin
                    if (w_complete && (bus.bus_wdata[ID_W-1:0] == ID_W'(i)) && r_en[i])
                        r_infl[i] <= 1'b0;
                end else if (r_pend[i]) begin
                    if (w_claim && (w_win_id == ID_W'(i))) begin
                        r_pend[i] <= 1'b0;
                        r_infl[i] <= 1'b1;
                    end
                end else if (w_set[i]) begin
                    r_pend[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.bus_ack   = r_ack;
    assign bus.bus_rdata = r_rdata;
    assign irq_ext       = r_irq;
endmodule

// File: tb/tb_plic_lite.sv
// Scoreboard bench for plic_lite: expected read data queued at issue, compared at bus_ack.
module tb_plic_lite;
    localparam int unsigned NUM_SRC = 8;
    localparam logic [23:0] A_PEND = 24'h001000;
    localparam logic [23:0] A_EN   = 24'h002000;
    localparam logic [23:0] A_THR  = 24'h200000;
    localparam logic [23:0] A_CLM  = 24'h200004;

    typedef struct packed {
        logic        rd;
        logic [31:0] d;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NUM_SRC-1:0] src = '0;
    logic               irq;
    int                 n_vec = 0;
    int                 n_err = 0;
    int                 ack_cnt = 0;
    int                 n0;
    exp_t               sb [$];
    string              tq [$];

    plic_lite_if bus ();

    plic_lite #(.NUM_SRC(NUM_SRC), .PRIO_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .irq_src (src),
        .irq_ext (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every ack must match the oldest outstanding request.
    always @(negedge clk) begin : mon
        exp_t  e;
        string t;
        if (bus.bus_ack) begin
            ack_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                t = tq.pop_front();
                if (e.rd) check(t, bus.bus_rdata, e.d);
            end
        end
    end

    task automatic xfer(input logic we, input logic [23:0] a, input logic [31:0] wd,
                        input logic [31:0] ed, input string tag);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        bus.bus_req   = 1'b1;
        bus.bus_we    = we;
        bus.bus_addr  = a;
        bus.bus_wdata = wd;
        e.rd = !we;
        e.d  = ed;
        sb.push_back(e);
        tq.push_back(tag);
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.bus_ack && n < 8);
        if (!bus.bus_ack) begin
            check({tag, "_ack_timeout"}, 32'd0, 32'd1);
            sb.delete();
            tq.delete();
        end
        bus.bus_req = 1'b0;
    endtask

    task automatic wr(input logic [23:0] a, input logic [31:0] d);
        xfer(1'b1, a, d, 32'd0, "wr");
    endtask

    task automatic rd(input logic [23:0] a, input logic [31:0] e, input string tag);
        xfer(1'b0, a, 32'd0, e, tag);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        src = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bus.bus_req   = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(bus.bus_ack), 32'd0);
        check("rst_rdata", bus.bus_rdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;

        // Reset state of every register
        for (int i = 0; i <= NUM_SRC; i++) rd(24'(4 * i), 32'd0, "t1_prio");
        rd(A_PEND, 32'd0, "t1_pend");
        rd(A_EN,   32'd0, "t1_en");
        rd(A_THR,  32'd0, "t1_thr");
        rd(A_CLM,  32'd0, "t1_claim");
        check("t1_irq", 32'(irq), 32'd0);

        // Single source claim/complete
        wr(24'd12, 32'd2);
        wr(A_EN, 32'h08);
        wr(A_THR, 32'd1);
        @(negedge clk);
        src[2] = 1'b1;
        repeat (2) @(negedge clk);
        check("t2_irq", 32'(irq), 32'd1);
        rd(A_PEND, 32'h08, "t2_pend");
        rd(A_CLM,  32'd3,  "t2_claim");
        rd(A_PEND, 32'd0,  "t2_pend_clr");
        src[2] = 1'b0;
        wr(A_CLM, 32'd3);
        repeat (2) @(negedge clk);
        check("t2_irq_off", 32'(irq), 32'd0);
        rd(A_PEND, 32'd0, "t2_idle");

        // Priority ordering and lowest-ID tie break
        reset_dut();
        wr(24'd8,  32'd5);
        wr(24'd20, 32'd5);
        wr(24'd24, 32'd7);
        wr(A_EN, 32'h64);
        @(negedge clk);
        src = '1;
        repeat (2) @(negedge clk);
        check("t3_irq", 32'(irq), 32'd1);
        rd(A_CLM, 32'd6, "t3_claim_a");
        rd(A_CLM, 32'd2, "t3_claim_b");
        rd(A_CLM, 32'd5, "t3_claim_c");
        rd(A_CLM, 32'd0, "t3_claim_none");
        rd(A_PEND, 32'h19A, "t3_pend_masked");

        // Threshold boundary: prio equal to threshold does not interrupt
        reset_dut();
        wr(24'd4, 32'd3);
        wr(A_THR, 32'd3);
        wr(A_EN, 32'h02);
        @(negedge clk);
        src[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_irq_eq_thr", 32'(irq), 32'd0);
        rd(A_PEND, 32'h02, "t4_pend");
        wr(A_THR, 32'd2);
        @(negedge clk);
        check("t4_irq_lag", 32'(irq), 32'd0);
        @(negedge clk);
        check("t4_irq_on", 32'(irq), 32'd1);
        rd(A_CLM, 32'd1, "t4_claim");

        // In-flight with line held high; wrong-ID complete ignored
        wr(A_CLM, 32'd4);
        rd(A_PEND, 32'd0, "t5_infl_pend");
        rd(A_CLM,  32'd0, "t5_infl_claim");
        wr(A_CLM, 32'd1);
`ifdef PLIC_EDGE_TRIG_EN
        rd(A_PEND, 32'd0, "t5_held_no_repend");
`else
        rd(A_PEND, 32'h02, "t5_repend");
`endif

        // Reset while a request is pending: no ack, all state cleared
        @(negedge clk);
        @(negedge clk);
        n0 = ack_cnt;
        bus.bus_req  = 1'b1;
        bus.bus_we   = 1'b0;
        bus.bus_addr = A_CLM;
        rst = 1'b1;
        src = '0;
        repeat (3) @(negedge clk);
        check("t6_no_ack", 32'(ack_cnt - n0), 32'd0);
        bus.bus_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("t6_irq", 32'(irq), 32'd0);
        rd(24'd4,  32'd0, "t6_prio1");
        rd(A_EN,   32'd0, "t6_en");
        rd(A_THR,  32'd0, "t6_thr");
        rd(A_PEND, 32'd0, "t6_pend");
        rd(A_CLM,  32'd0, "t6_claim");

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
